dsram_responder: RTL and testbench

- Synchronous data-memory responder on the far side of the EX-stage data SRAM interface (en / wen / addr / wdata).
- Commits byte-lane stores, serves loads after a configurable latency and returns an aligned, sign- or zero-extended load result for MEM/WB.
- Raises stallreq during wait states so the pipeline stall controller can hold the stages.
- Flags misaligned accesses.

---
 rtl/dsram_if.sv | 26 ++
 rtl/dsram_responder.sv | 182 ++++++++++++++++++
 tb/tb_dsram_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dsram_if.sv
// Data-SRAM request/response bundle between the EX/MEM pipeline (master) and
// the data-memory responder (slave).
//   en/wen/addr/wdata/load_op : request, driven by the master
//   resp_valid/load_result/rdata_raw/stallreq/err_misalign : response, driven by the slave
interface dsram_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  load_op;
    logic        resp_valid;
    logic [31:0] load_result;
    logic [31:0] rdata_raw;
    logic        stallreq;
    logic        err_misalign;

    modport master (
        output en, wen, addr, wdata, load_op,
        input  resp_valid, load_result, rdata_raw, stallreq, err_misalign
    );

    modport slave (
        input  en, wen, addr, wdata, load_op,
        output resp_valid, load_result, rdata_raw, stallreq, err_misalign
    );
endinterface

// File: rtl/dsram_responder.sv
// Data-memory responder: commits byte-lane stores, answers loads after
// WAIT_CYCLES extra wait states with an aligned, sign/zero-extended result,
// holds stallreq while waiting and flags misaligned accesses.
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   bus         dsram_if.slave: request (en, wen, addr, wdata, load_op) in,
//               response (resp_valid, load_result, rdata_raw, stallreq,
//               err_misalign) out, all responses registered
module dsram_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic    clk,
    input logic    rst,
    dsram_if.slave bus
);
    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [2:0]  OP_LB     = 3'd1;
    localparam logic [2:0]  OP_LBU    = 3'd2;
    localparam logic [2:0]  OP_LH     = 3'd3;
    localparam logic [2:0]  OP_LHU    = 3'd4;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    // Loads: LW needs word alignment, halves need even offsets, bytes never fault.
    function automatic logic load_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            OP_LB, OP_LBU: return 1'b0;
            OP_LH, OP_LHU: return off[0];
            default:       return off != 2'b00;
        endcase
    endfunction

    // Stores: full-word and half-word lane patterns must sit on their natural boundary.
    function automatic logic store_misaligned(input logic [3:0] wen, input logic [1:0] off);
        return ((wen == 4'b1111) && (off != 2'b00)) ||
               (((wen == 4'b0011) || (wen == 4'b1100)) && off[0]);
    endfunction

    // Select the addressed byte/half from the raw word and extend it.
    function automatic logic [31:0] align_load(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic [31:0]       mem_word;
    logic              accept, is_store, do_write;
    logic [31:0]       cap_word;
    logic [1:0]        cap_off;
    logic [2:0]        cap_op;
    logic              resp_valid_q, resp_valid_nxt;
    logic              err_q, err_nxt;
    logic              stall_q, stall_nxt;
    logic [31:0]       result_q, result_nxt;
    logic [31:0]       raw_q, raw_nxt;
    logic              unused_addr;

    assign idx         = bus.addr[ADDR_W+1:2];
    assign off         = bus.addr[1:0];
    assign mem_word    = mem[idx];
    assign accept      = bus.en && (state == ST_IDLE);
    assign is_store    = bus.wen != 4'b0000;
    assign do_write    = !rst && accept && is_store && !store_misaligned(bus.wen, off);
    assign unused_addr = &{1'b0, bus.addr[31:ADDR_W+2]};

    assign bus.resp_valid   = resp_valid_q;
    assign bus.load_result  = result_q;
    assign bus.rdata_raw    = raw_q;
    assign bus.stallreq     = stall_q;
    assign bus.err_misalign = err_q;

    // Byte-lane store commit; array is not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wen[i]) begin
                    mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // Snapshot of the word and access shape for a load answered from WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_word <= '0;
            cap_off  <= '0;
            cap_op   <= '0;
        end else if (accept && !is_store) begin
            cap_word <= mem_word;
            cap_off  <= off;
            cap_op   <= bus.load_op;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            stall_q      <= 1'b0;
            result_q     <= '0;
            raw_q        <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            resp_valid_q <= resp_valid_nxt;
            err_q        <= err_nxt;
            stall_q      <= stall_nxt;
            result_q     <= result_nxt;
            raw_q        <= raw_nxt;
        end
    end

    // Next state and next output values.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        resp_valid_nxt = 1'b0;
        err_nxt        = 1'b0;
        stall_nxt      = 1'b0;
        result_nxt     = result_q;
        raw_nxt        = raw_q;
        case (state)
            ST_IDLE: begin
                if (bus.en) begin
                    if (is_store) begin
                        err_nxt = store_misaligned(bus.wen, off);
                    end else if (WAIT_CYCLES == 0) begin
                        resp_valid_nxt = 1'b1;
                        raw_nxt        = mem_word;
                        err_nxt        = load_misaligned(bus.load_op, off);
                        result_nxt     = err_nxt ? 32'h0 : align_load(mem_word, off, bus.load_op);
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WAIT_INIT;
                        stall_nxt = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Last wait cycle: present the snapshot next cycle and release the stall.
                if (cnt == 4'd1) begin
                    state_nxt      = ST_IDLE;
                    cnt_nxt        = 4'd0;
                    resp_valid_nxt = 1'b1;
                    raw_nxt        = cap_word;
                    err_nxt        = load_misaligned(cap_op, cap_off);
                    result_nxt     = err_nxt ? 32'h0 : align_load(cap_word, cap_off, cap_op);
                end else begin
                    cnt_nxt   = cnt - 4'd1;
                    stall_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: two instances (WAIT_CYCLES 0 and 3) see the same
// request stream; a per-instance reference model predicts responses into a
// scoreboard queue and a monitor checks outputs every cycle.
module tb_dsram_responder;
    localparam int N_DUT = 2;

    typedef struct {
        int          k;
        int          due;
        logic        rv;
        logic        er;
        logic [31:0] lr;
        logic [31:0] raw;
    } exp_t;

    logic        clk = 1'b0;
    logic        d_rst = 1'b1;
    logic        d_en = 1'b0;
    logic [3:0]  d_wen = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_op = '0;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          busy_until [N_DUT];
    int          wait_n [N_DUT];
    logic [31:0] mm [N_DUT][4096];
    exp_t        exq [$];

    dsram_if if0 ();
    dsram_if if3 ();

    assign if0.en = d_en;      assign if3.en = d_en;
    assign if0.wen = d_wen;    assign if3.wen = d_wen;
    assign if0.addr = d_addr;  assign if3.addr = d_addr;
    assign if0.wdata = d_wdata; assign if3.wdata = d_wdata;
    assign if0.load_op = d_op; assign if3.load_op = d_op;

    dsram_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(d_rst), .bus(if0.slave));
    dsram_responder #(.ADDR_W(12), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(d_rst), .bus(if3.slave));

    always #5 clk = ~clk;

    // Reference load semantics from shifts and masks.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int op,
                                             output logic mis);
        logic [31:0] v;
        case (op)
            1, 2: begin
                mis = 1'b0;
                v = (w >> (8 * off)) & 32'h0000_00FF;
                if (op == 1 && v[7]) v = v | 32'hFFFF_FF00;
            end
            3, 4: begin
                mis = (off % 2) != 0;
                v = (w >> (8 * off)) & 32'h0000_FFFF;
                if (op == 3 && v[15]) v = v | 32'hFFFF_0000;
            end
            default: begin
                mis = off != 0;
                v = w;
            end
        endcase
        return mis ? 32'h0 : v;
    endfunction

    task automatic model_edge(input int k);
        int   idx, off;
        exp_t e;
        logic mis;
        logic [31:0] mask;
        if (!d_en || cyc <= busy_until[k]) return;
        idx = int'(d_addr[13:2]);
        off = int'(d_addr[1:0]);
        e.k = k; e.rv = 1'b0; e.er = 1'b0; e.lr = '0; e.raw = '0; e.due = cyc;
        if (d_wen != 4'b0000) begin
            mis = (d_wen == 4'hF && off != 0) || ((d_wen == 4'h3 || d_wen == 4'hC) && (off % 2) == 1);
            if (mis) begin
                e.er = 1'b1;
                exq.push_back(e);
            end else begin
                mask = '0;
                for (int i = 0; i < 4; i++) if (d_wen[i]) mask = mask | (32'hFF << (8 * i));
                mm[k][idx] = (mm[k][idx] & ~mask) | (d_wdata & mask);
            end
        end else begin
            e.due = cyc + wait_n[k];
            e.rv  = 1'b1;
            e.raw = mm[k][idx];
            e.lr  = ref_load(mm[k][idx], off, int'(d_op), mis);
            e.er  = mis;
            busy_until[k] = cyc + wait_n[k];
            exq.push_back(e);
        end
    endtask

    // Reference model advances at every active edge.
    initial begin
        wait_n[0] = 0;
        wait_n[1] = 3;
        busy_until[0] = 0;
        busy_until[1] = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (d_rst) begin
                exq.delete();
                for (int k = 0; k < N_DUT; k++) busy_until[k] = cyc;
            end else begin
                for (int k = 0; k < N_DUT; k++) model_edge(k);
            end
        end
    end

    task automatic mon(input int k, input logic rv, input logic er, input logic [31:0] lr,
                       input logic [31:0] raw, input logic st);
        int   fi;
        exp_t e;
        logic st_exp;
        st_exp = cyc < busy_until[k];
        checks++;
        if (st !== st_exp) begin
            errors++;
            $display("FAIL stallreq dut%0d cyc %0d: got %b want %b", k, cyc, st, st_exp);
        end
        fi = -1;
        foreach (exq[i]) if (fi < 0 && exq[i].k == k) fi = i;
        if (rv === 1'b1 || er === 1'b1) begin
            checks++;
            if (fi < 0 || exq[fi].due != cyc) begin
                errors++;
                $display("FAIL unexpected_resp dut%0d cyc %0d: got rv=%b err=%b lr=%h, want none",
                         k, cyc, rv, er, lr);
            end else begin
                e = exq[fi];
                exq.delete(fi);
                if (rv !== e.rv || er !== e.er || (e.rv && (lr !== e.lr || raw !== e.raw))) begin
                    errors++;
                    $display("FAIL resp dut%0d cyc %0d: got rv=%b err=%b lr=%h raw=%h, want rv=%b err=%b lr=%h raw=%h",
                             k, cyc, rv, er, lr, raw, e.rv, e.er, e.lr, e.raw);
                end
            end
        end else if (fi >= 0 && exq[fi].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_resp dut%0d cyc %0d: got none, want rv=%b err=%b lr=%h",
                     k, cyc, exq[fi].rv, exq[fi].er, exq[fi].lr);
            exq.delete(fi);
        end
    endtask

    // Monitor samples outputs on the inactive edge.
    initial begin
        forever begin
            @(negedge clk);
            mon(0, if0.resp_valid, if0.err_misalign, if0.load_result, if0.rdata_raw, if0.stallreq);
            mon(1, if3.resp_valid, if3.err_misalign, if3.load_result, if3.rdata_raw, if3.stallreq);
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if ({if0.resp_valid, if0.err_misalign, if0.stallreq, if0.load_result, if0.rdata_raw} !== '0) begin
            errors++;
            $display("FAIL %s dut0: got rv=%b err=%b st=%b lr=%h raw=%h, want all 0", name,
                     if0.resp_valid, if0.err_misalign, if0.stallreq, if0.load_result, if0.rdata_raw);
        end
        checks++;
        if ({if3.resp_valid, if3.err_misalign, if3.stallreq, if3.load_result, if3.rdata_raw} !== '0) begin
            errors++;
            $display("FAIL %s dut3: got rv=%b err=%b st=%b lr=%h raw=%h, want all 0", name,
                     if3.resp_valid, if3.err_misalign, if3.stallreq, if3.load_result, if3.rdata_raw);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] op);
        d_rst = r; d_en = e; d_wen = w; d_addr = a; d_wdata = wd; d_op = op;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'd0);
    endtask

    task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] op, input int gap);
        step(1'b0, 1'b1, w, a, wd, op);
        idle(gap);
    endtask

    initial begin
        logic [31:0] alias_bits;
        logic [3:0]  w;
        repeat (2) @(negedge clk);
        check_zero("reset_state");

        // Preload the region the random phase touches.
        for (int i = 0; i < 8; i++) req(4'hF, 32'h40 + 32'(4 * i), $urandom, 3'd0, 0);
        idle(2);

        // Directed: word, extensions, partial stores, misalignment.
        req(4'hF, 32'h40, 32'hDEADBEEF, 3'd0, 1);
        req(4'h0, 32'h40, 32'h0, 3'd0, 5);
        req(4'h0, 32'h43, 32'h0, 3'd1, 5);
        req(4'h0, 32'h43, 32'h0, 3'd2, 5);
        req(4'h0, 32'h42, 32'h0, 3'd3, 5);
        req(4'h0, 32'h40, 32'h0, 3'd4, 5);
        req(4'h4, 32'h40, 32'h00550000, 3'd0, 1);
        req(4'h0, 32'h40, 32'h0, 3'd0, 5);
        req(4'h3, 32'h40, 32'h00001234, 3'd0, 1);
        req(4'h0, 32'h40, 32'h0, 3'd0, 5);
        req(4'h0, 32'h41, 32'h0, 3'd0, 5);
        req(4'hF, 32'h42, 32'h11111111, 3'd0, 1);
        req(4'h0, 32'h40, 32'h0, 3'd0, 5);

        // Store issued while the waiting instance is busy; then read it back.
        req(4'h0, 32'h40, 32'h0, 3'd0, 0);
        req(4'hF, 32'h44, 32'hCAFEF00D, 3'd0, 5);
        req(4'h0, 32'h44, 32'h0, 3'd0, 5);

        // New load in the same cycle as the previous response.
        req(4'h0, 32'h40, 32'h0, 3'd1, 3);
        req(4'h0, 32'h44, 32'h0, 3'd3, 5);

        // Reset one cycle after accept.
        req(4'h0, 32'h40, 32'h0, 3'd0, 0);
        step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 3'd0);
        check_zero("reset_mid_wait");
        idle(4);
        req(4'h0, 32'h40, 32'h0, 3'd0, 5);

        // Randomized traffic.
        for (int t = 0; t < 800; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: w = 4'h0;
                3:       w = 4'hF;
                4:       w = 4'h3;
                5:       w = 4'hC;
                6:       w = 4'(1 << $urandom_range(0, 3));
                default: w = 4'($urandom);
            endcase
            alias_bits = (32'($urandom_range(0, 1)) << 14) | (32'($urandom_range(0, 1)) << 30);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1), w,
                 32'h40 + 32'($urandom_range(0, 31)) + alias_bits, $urandom, 3'($urandom_range(0, 7)));
        end
        idle(8);

        checks++;
        if (exq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses, want 0", exq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
